cpu_bus_arbiter: RTL
====================

Name: cpu_bus_arbiter

Overview:
- Shares one external memory bus between the CPU instruction bus (ibus, read-only) and data bus (dbus, read/write) for a single-port memory system.
- Sits between the CPU top-level ibus/dbus ports and the system bus.
- Fixed data-bus priority, with a starvation limit so fetch always progresses.
- Registered request/ready handshake on every side, matching the CPU bus protocol.

Parameters:
- STARVE_LIMIT, 4, consecutive dbus grants allowed while ibus is pending before ibus is forced; legal range 1..15.
- TIMEOUT_CYCLES, 1024, cycles in GRANT without i_bus_ready before abort; used only with the optional feature; legal range 2..65535.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_ibus_request  in  1  ibus read request, held until o_ibus_ready is seen
- o_ibus_ready  out  1  one-cycle completion pulse to ibus
- i_ibus_address  in  32  ibus address
- o_ibus_rdata  out  32  ibus read data, valid with o_ibus_ready
- i_dbus_rw  in  1  1 = write, 0 = read
- i_dbus_request  in  1  dbus request, held until o_dbus_ready is seen
- o_dbus_ready  out  1  one-cycle completion pulse to dbus
- i_dbus_address  in  32  dbus address
- i_dbus_wdata  in  32  dbus write data
- o_dbus_rdata  out  32  dbus read data, valid with o_dbus_ready
- o_bus_rw  out  1  bus direction
- o_bus_request  out  1  bus request
- i_bus_ready  in  1  bus completion pulse
- o_bus_address  out  32  bus address
- i_bus_rdata  in  32  bus read data
- o_bus_wdata  out  32  bus write data
- o_grant  out  2  debug: 00 none, 01 ibus, 10 dbus
- o_timeout  out  1  sticky abort flag; tied 0 without the optional feature

Behaviour:
- All outputs are registered. On i_reset == 0 at a clock edge, everything returns to reset state next cycle:
  - state = IDLE; all ready/request outputs 0; address/wdata/rdata 0; o_bus_rw 0.
  - o_grant 00; starve counter 0; o_timeout 0.
- Reset mid-transaction abandons the bus cycle; o_bus_request is low the cycle after reset.
- FSM states: IDLE, GRANT, ACK.
- IDLE, decision rules:
  - Both requests high and starve counter < STARVE_LIMIT: dbus wins, starve counter +1.
  - Both requests high and starve counter == STARVE_LIMIT: ibus wins.
  - Only one request high: that requester wins.
  - Any ibus grant clears the starve counter. A dbus grant with ibus idle also clears it.
- IDLE, on a grant:
  - Latch address, rw and wdata into o_bus_*. For an ibus grant, o_bus_rw = 0 and o_bus_wdata = 0.
  - Set o_bus_request = 1, update o_grant, go to GRANT.
  - No request: remain in IDLE.
- GRANT:
  - o_bus_* stay stable; requester inputs are not resampled.
  - On i_bus_ready == 1: o_bus_request <= 0; the granted requester's rdata <= i_bus_rdata and its ready <= 1; go to ACK.
  - The non-granted requester's rdata holds its old value.
- ACK:
  - Ready drops to 0, o_grant <= 00, go to IDLE.
  - The requester samples ready at this edge and deasserts its request, so IDLE never re-grants a finished request.
- Latency from request to ready is bus latency + 2 cycles: request seen in IDLE, granted at the next edge, i_bus_ready at the earliest the following cycle, ready pulse one cycle after that.
- i_bus_ready outside GRANT is ignored.
- A request that drops during GRANT is still completed; the ready pulse is issued anyway.
- Widths: the starve counter is 4 bits and saturates at STARVE_LIMIT. The timeout counter is 16 bits and clears on entry to GRANT.

Optional Feature:
- Macro: CPU_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - In GRANT, the timeout counter increments each cycle without i_bus_ready.
  - When it reaches TIMEOUT_CYCLES - 1 with no ready: o_bus_request <= 0; the granted requester gets ready = 1 and rdata = 32'hFFFF_FFFF; o_timeout <= 1 (cleared only by reset); go to ACK.
  - If ready and the timeout occur in the same cycle, ready wins: normal data, no flag.
- Undefined: no counter; GRANT waits forever; o_timeout is constant 0.

Test Plan:
- Reset: hold i_reset = 0 for 3 cycles with both requests high -> all outputs 0, o_grant 00; first grant occurs 1 cycle after i_reset goes to 1.
- Single read: ibus request at 0x100, bus returns 0xDEADBEEF after 3 cycles -> o_bus_address = 0x100, o_bus_rw = 0; one-cycle o_ibus_ready with rdata 0xDEADBEEF 1 cycle after i_bus_ready; total 5 cycles from request.
- Write: dbus rw = 1, address 0x2000_0010, wdata 0x12345678 -> bus carries exactly those values stable for the whole of GRANT; o_dbus_ready pulses once.
- Priority/starvation with STARVE_LIMIT = 4: both requesters request continuously, bus ready 1 cycle after each request -> grant order D, D, D, D, I, D, D, D, D, I.
- Reset mid-GRANT: i_reset = 0 while o_bus_request = 1 -> o_bus_request = 0 next cycle; no ready pulse is issued.
- Timeout (macro defined, TIMEOUT_CYCLES = 8): dbus read, bus never ready -> o_dbus_ready after 8 GRANT cycles with rdata 0xFFFFFFFF; o_timeout = 1 and stays 1; the next ibus request is served normally.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// Bus bundle between the CPU ibus/dbus ports, the arbiter and the shared system bus.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface cpu_bus_arbiter_if;
   logic        i_ibus_request;
   logic        o_ibus_ready;
   logic [31:0] i_ibus_address;
   logic [31:0] o_ibus_rdata;
   logic        i_dbus_rw;
   logic        i_dbus_request;
   logic        o_dbus_ready;
   logic [31:0] i_dbus_address;
   logic [31:0] i_dbus_wdata;
   logic [31:0] o_dbus_rdata;
   logic        o_bus_rw;
   logic        o_bus_request;
   logic        i_bus_ready;
   logic [31:0] o_bus_address;
   logic [31:0] i_bus_rdata;
   logic [31:0] o_bus_wdata;

   modport slave (
      input  i_ibus_request, i_ibus_address, i_dbus_rw, i_dbus_request,
             i_dbus_address, i_dbus_wdata, i_bus_ready, i_bus_rdata,
      output o_ibus_ready, o_ibus_rdata, o_dbus_ready, o_dbus_rdata,
             o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata
   );

   modport master (
      output i_ibus_request, i_ibus_address, i_dbus_rw, i_dbus_request,
             i_dbus_address, i_dbus_wdata, i_bus_ready, i_bus_rdata,
      input  o_ibus_ready, o_ibus_rdata, o_dbus_ready, o_dbus_rdata,
             o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata
   );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// ibus/dbus arbiter onto one memory bus: dbus priority with an ibus starvation limit.
// Optional GRANT watchdog enabled by macro CPU_BUS_ARBITER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request; arbitration and bus latch happen here
// GRANT | bus cycle in flight, waiting for i_bus_ready
// ACK   | ready pulse visible to the requester; back to IDLE next
module cpu_bus_arbiter #(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic             i_clock,
   input  logic             i_reset,
   cpu_bus_arbiter_if.slave bus,
   output logic [1:0]       o_grant,
   output logic             o_timeout
);
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("cpu_bus_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [1:0] G_NONE     = 2'b00;
   localparam logic [1:0] G_IBUS     = 2'b01;
   localparam logic [1:0] G_DBUS     = 2'b10;

   state_t      r_state,       w_state_nxt;
   logic [3:0]  r_starve,      w_starve_nxt;
   logic [1:0]  r_grant,       w_grant_nxt;
   logic        r_bus_request, w_bus_request_nxt;
   logic        r_bus_rw,      w_bus_rw_nxt;
   logic [31:0] r_bus_address, w_bus_address_nxt;
   logic [31:0] r_bus_wdata,   w_bus_wdata_nxt;
   logic        r_ibus_ready,  w_ibus_ready_nxt;
   logic [31:0] r_ibus_rdata,  w_ibus_rdata_nxt;
   logic        r_dbus_ready,  w_dbus_ready_nxt;
   logic [31:0] r_dbus_rdata,  w_dbus_rdata_nxt;
   logic        w_cpl_en;
   logic [31:0] w_cpl_data;

`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
   logic        r_timeout, w_timeout_nxt;
`endif

   always_comb begin
      w_state_nxt       = r_state;
      w_starve_nxt      = r_starve;
      w_grant_nxt       = r_grant;
      w_bus_request_nxt = r_bus_request;
      w_bus_rw_nxt      = r_bus_rw;
      w_bus_address_nxt = r_bus_address;
      w_bus_wdata_nxt   = r_bus_wdata;
      w_ibus_ready_nxt  = r_ibus_ready;
      w_ibus_rdata_nxt  = r_ibus_rdata;
      w_dbus_ready_nxt  = r_dbus_ready;
      w_dbus_rdata_nxt  = r_dbus_rdata;
      w_cpl_en          = 1'b0;
      w_cpl_data        = bus.i_bus_rdata;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
      w_tmo_cnt_nxt     = r_tmo_cnt;
      w_timeout_nxt     = r_timeout;
`endif
      unique case (r_state)
         IDLE: begin
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
            w_tmo_cnt_nxt = '0;
`endif
            // dbus wins unless ibus has been passed over STARVE_LIMIT times in a row
            if (bus.i_dbus_request && (!bus.i_ibus_request || (r_starve < STARVE_MAX))) begin
               w_starve_nxt      = bus.i_ibus_request ? r_starve + 4'd1 : 4'd0;
               w_grant_nxt       = G_DBUS;
               w_bus_request_nxt = 1'b1;
               w_bus_rw_nxt      = bus.i_dbus_rw;
               w_bus_address_nxt = bus.i_dbus_address;
               w_bus_wdata_nxt   = bus.i_dbus_wdata;
               w_state_nxt       = GRANT;
            end else if (bus.i_ibus_request) begin
               w_starve_nxt      = 4'd0;
               w_grant_nxt       = G_IBUS;
               w_bus_request_nxt = 1'b1;
               w_bus_rw_nxt      = 1'b0;
               w_bus_address_nxt = bus.i_ibus_address;
               w_bus_wdata_nxt   = '0;
               w_state_nxt       = GRANT;
            end
         end
         GRANT: begin
            if (bus.i_bus_ready) begin
               w_cpl_en = 1'b1;
            end
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
            else if (r_tmo_cnt == TMO_LAST) begin
               w_cpl_en      = 1'b1;
               w_cpl_data    = 32'hFFFF_FFFF;
               w_timeout_nxt = 1'b1;
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
            end
`endif
         end
         ACK: begin
            w_ibus_ready_nxt = 1'b0;
            w_dbus_ready_nxt = 1'b0;
            w_grant_nxt      = G_NONE;
            w_state_nxt      = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_cpl_en) begin
         w_bus_request_nxt = 1'b0;
         w_state_nxt       = ACK;
         if (r_grant == G_IBUS) begin
            w_ibus_ready_nxt = 1'b1;
            w_ibus_rdata_nxt = w_cpl_data;
         end else begin
            w_dbus_ready_nxt = 1'b1;
            w_dbus_rdata_nxt = w_cpl_data;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state       <= IDLE;
         r_starve      <= '0;
         r_grant       <= G_NONE;
         r_bus_request <= 1'b0;
         r_bus_rw      <= 1'b0;
         r_bus_address <= '0;
         r_bus_wdata   <= '0;
         r_ibus_ready  <= 1'b0;
         r_ibus_rdata  <= '0;
         r_dbus_ready  <= 1'b0;
         r_dbus_rdata  <= '0;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
         r_tmo_cnt     <= '0;
         r_timeout     <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_starve      <= w_starve_nxt;
         r_grant       <= w_grant_nxt;
         r_bus_request <= w_bus_request_nxt;
         r_bus_rw      <= w_bus_rw_nxt;
         r_bus_address <= w_bus_address_nxt;
         r_bus_wdata   <= w_bus_wdata_nxt;
         r_ibus_ready  <= w_ibus_ready_nxt;
         r_ibus_rdata  <= w_ibus_rdata_nxt;
         r_dbus_ready  <= w_dbus_ready_nxt;
         r_dbus_rdata  <= w_dbus_rdata_nxt;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
         r_tmo_cnt     <= w_tmo_cnt_nxt;
         r_timeout     <= w_timeout_nxt;
`endif
      end
   end

   assign bus.o_ibus_ready  = r_ibus_ready;
   assign bus.o_ibus_rdata  = r_ibus_rdata;
   assign bus.o_dbus_ready  = r_dbus_ready;
   assign bus.o_dbus_rdata  = r_dbus_rdata;
   assign bus.o_bus_rw      = r_bus_rw;
   assign bus.o_bus_request = r_bus_request;
   assign bus.o_bus_address = r_bus_address;
   assign bus.o_bus_wdata   = r_bus_wdata;
   assign o_grant           = r_grant;
`ifdef CPU_BUS_ARBITER_TIMEOUT_EN
   assign o_timeout         = r_timeout;
`else
   assign o_timeout         = 1'b0;
`endif
endmodule
